usb_crc_stream: RTL and testbench

//  Parametrised, multi-bit-per-cycle CRC engine for the SIE packet path.
//  - Consumes DATA_W bits per clk12 beat over a valid/ready stream.
//  - GEN mode: forwards the payload, then appends the inverted CRC.
//  - CHK mode: consumes payload+CRC and reports a residual match.
//  - Serves both CRC5 (tokens, DATA_W=1) and CRC16 (data packets, DATA_W=8).

---
 rtl/usb_crc_stream.sv | 152 +++++++++++++++
 tb/tb_usb_crc_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_stream.sv
// Multi-bit-per-beat CRC engine for the SIE packet path: GEN mode forwards the
// payload and appends the inverted CRC, CHK mode consumes payload+CRC and checks the residual.
module usb_crc_stream #(
  parameter int                 CRC_W    = 16,
  parameter logic [CRC_W-1:0]   POLY     = 16'h8005,
  parameter logic [CRC_W-1:0]   RESIDUAL = 16'h800D,
  parameter int                 DATA_W   = 8
) (
  input  logic              clk12,
  input  logic              RST,
  input  logic              mode,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              crc_done,
  output logic              crc_ok,
  output logic [CRC_W-1:0]  crc
);

  localparam int NCRC = CRC_W / DATA_W;
  localparam int BW = (NCRC > 1) ? $clog2(NCRC) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NCRC - 1);

  generate
    if (CRC_W % DATA_W != 0) begin : g_bad_width
      $error("usb_crc_stream: CRC_W must be a multiple of DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, STREAM, APPEND, RESULT} state_t;

  state_t            state_reg, state_next;
  logic [CRC_W-1:0]  crc_reg, crc_next;
  logic              mode_reg, mode_next;
  logic [BW-1:0]     beat_reg, beat_next;
  logic              gen_path;
  logic              accept;

  // Chained LSB-first bit steps, one whole beat per cycle.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  // crc_reg does not move during APPEND, so the reversed complement is frozen for free.
  logic [CRC_W-1:0]  r_bits;
  logic [DATA_W-1:0] r_beats [NCRC];

  genvar gi;
  generate
    for (gi = 0; gi < CRC_W; gi++) begin : g_rev
      assign r_bits[gi] = ~crc_reg[CRC_W-1-gi];
    end
    for (gi = 0; gi < NCRC; gi++) begin : g_beats
      assign r_beats[gi] = r_bits[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    mode_next  = mode_reg;
    beat_next  = beat_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    crc_done   = 1'b0;
    crc_ok     = 1'b0;
    accept     = 1'b0;
    // Until the first beat latches mode, the live input picks the path.
    gen_path   = (state_reg == IDLE) ? mode : mode_reg;

    case (state_reg)
      IDLE, STREAM: begin
        if (gen_path) begin
          out_valid = in_valid;
          out_data  = in_data;
          in_ready  = out_ready;
        end else begin
          in_ready = 1'b1;
        end
        accept = in_valid & in_ready;
        if (accept) begin
          crc_next  = crc_step(crc_reg, in_data);
          beat_next = '0;
          if (state_reg == IDLE) mode_next = mode;
          if (in_last) state_next = gen_path ? APPEND : RESULT;
          else         state_next = STREAM;
        end
      end
      APPEND: begin
        out_valid = 1'b1;
        out_data  = r_beats[beat_reg];
        out_last  = (beat_reg == LAST_BEAT);
        if (out_ready) begin
          if (out_last) state_next = RESULT;
          else          beat_next  = beat_reg + 1'b1;
        end
      end
      RESULT: begin
        crc_done   = 1'b1;
        crc_ok     = mode_reg | (crc_reg == RESIDUAL);
        crc_next   = '1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over any handshake: nothing is accepted or offered this cycle.
    if (abort) begin
      state_next = IDLE;
      crc_next   = '1;
      beat_next  = '0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      crc_done   = 1'b0;
      crc_ok     = 1'b0;
    end
  end

  always_ff @(posedge clk12) begin
    if (RST) begin
      state_reg <= IDLE;
      crc_reg   <= '1;
      mode_reg  <= 1'b0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      mode_reg  <= mode_next;
      beat_reg  <= beat_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: tb/tb_usb_crc_stream.sv
// Bench for usb_crc_stream: CRC16/8-bit and CRC5/1-bit instances checked against
// a reflected (right-shifting) CRC model, plus abort and reset corner sequences.
module tb_usb_crc_stream;

  logic clk12 = 1'b0;
  logic rst;
  always #5 clk12 = ~clk12;

  logic       m16, ab16, iv16, ir16, il16, ov16, or16, ol16, done16, ok16;
  logic [7:0] id16, od16;
  logic [15:0] crc16;

  logic       m5, ab5, iv5, ir5, il5, ov5, or5, ol5, done5, ok5;
  logic [0:0] id5, od5;
  logic [4:0] crc5;

  int vectors = 0;
  int miscompares = 0;

  usb_crc_stream #(.CRC_W(16), .POLY(16'h8005), .RESIDUAL(16'h800D), .DATA_W(8)) u16 (
    .clk12(clk12), .RST(rst), .mode(m16), .abort(ab16),
    .in_valid(iv16), .in_ready(ir16), .in_data(id16), .in_last(il16),
    .out_valid(ov16), .out_ready(or16), .out_data(od16), .out_last(ol16),
    .crc_done(done16), .crc_ok(ok16), .crc(crc16)
  );

  usb_crc_stream #(.CRC_W(5), .POLY(5'h05), .RESIDUAL(5'h0C), .DATA_W(1)) u5 (
    .clk12(clk12), .RST(rst), .mode(m5), .abort(ab5),
    .in_valid(iv5), .in_ready(ir5), .in_data(id5), .in_last(il5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_last(ol5),
    .crc_done(done5), .crc_ok(ok5), .crc(crc5)
  );

  typedef bit bitq_t[$];
  typedef struct {int len; bit rnd; int flip; bit exp_ok; logic [3:0] pat;} vec16_t;
  typedef struct {logic [10:0] tok; int flip; bit exp_ok; bit timed;} vec5_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reflected model: register shifts right, reflected polynomial, starts all ones.
  function automatic logic [15:0] ref_crc(input logic [15:0] rpoly, input int w, input bitq_t bits);
    logic [15:0] mask, r;
    mask = 16'((32'd1 << w) - 32'd1);
    r = mask;
    foreach (bits[i]) begin
      if (r[0] ^ bits[i]) r = (r >> 1) ^ rpoly;
      else                r = r >> 1;
    end
    return r & mask;
  endfunction

  function automatic logic [15:0] brev(input logic [15:0] x, input int w);
    logic [15:0] y;
    y = '0;
    for (int i = 0; i < w; i++) y[i] = x[w-1-i];
    return y;
  endfunction

  function automatic bitq_t to_bits(input logic [7:0] q[$]);
    bitq_t b;
    foreach (q[i]) for (int k = 0; k < 8; k++) b.push_back(q[i][k]);
    return b;
  endfunction

  // GEN packet on the CRC16 instance; returns the complete output stream.
  task automatic run_gen16(input logic [7:0] pl[$], input bit rnd, input logic [3:0] pat,
                           output logic [7:0] got[$]);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] held_val;
    logic [15:0] r;
    int idx = 0, ai = 0, cyc = 0, last_acc = -1;
    bit finished = 0, held = 0, acc;
    r = ref_crc(16'hA001, 16, to_bits(pl));
    exp_q = pl;
    exp_q.push_back(~r[7:0]);
    exp_q.push_back(~r[15:8]);
    while (!finished && cyc < 300) begin
      ab16 = 1'b0;
      if (idx < pl.size()) begin
        iv16 = rnd ? ($urandom_range(3) != 0) : 1'b1;
        id16 = pl[idx];
        il16 = (idx == pl.size() - 1);
        m16  = (idx == 0) ? 1'b1 : 1'($urandom);
        or16 = rnd ? ($urandom_range(3) != 0) : 1'b1;
      end else begin
        iv16 = 1'($urandom);
        id16 = 8'($urandom);
        il16 = 1'($urandom);
        m16  = 1'($urandom);
        or16 = pat[ai % 4];
        ai++;
      end
      @(negedge clk12);
      acc = iv16 & ir16;
      if (ov16 && or16) begin
        got_q.push_back(od16);
        chk("gen_out_last", 32'(ol16), 32'(got_q.size() == exp_q.size()));
      end
      if (idx < pl.size()) begin
        chk("gen_pass_valid", 32'(ov16), 32'(iv16));
        chk("gen_pass_data", 32'(od16), 32'(id16));
        chk("gen_pass_ready", 32'(ir16), 32'(or16));
        chk("gen_no_early_done", 32'(done16), 0);
        if (acc) idx++;
      end else begin
        chk("gen_append_in_ready", 32'(ir16), 0);
        if (held) begin
          chk("gen_hold_valid", 32'(ov16), 1);
          chk("gen_hold_data", 32'(od16), 32'(held_val));
        end
        held = ov16 & ~or16;
        held_val = od16;
        if (ov16 && or16 && got_q.size() == exp_q.size()) last_acc = cyc;
        if (last_acc >= 0 && cyc == last_acc + 1) begin
          chk("gen_done", 32'(done16), 1);
          chk("gen_ok", 32'(ok16), 1);
          chk("gen_crc_reg", 32'(crc16), 32'(brev(r, 16)));
          finished = 1;
        end else begin
          chk("gen_done_quiet", 32'(done16), 0);
        end
      end
      @(posedge clk12);
      #1;
      cyc++;
    end
    iv16 = 1'b0;
    if (!finished) chk("gen_timeout", 0, 1);
    chk("gen_stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i < got_q.size()) chk("gen_stream_beat", 32'(got_q[i]), 32'(exp_q[i]));
    got = got_q;
  endtask

  // CHK packet on the CRC16 instance; flip >= 0 corrupts bit 3 of that byte.
  task automatic run_chk16(input logic [7:0] q[$], input int flip, input bit exp_ok);
    logic [7:0] s[$];
    logic [15:0] r;
    int idx = 0, cyc = 0, last_cyc = -10;
    bit finished = 0, acc;
    s = q;
    if (flip >= 0) s[flip] = s[flip] ^ 8'h08;
    r = ref_crc(16'hA001, 16, to_bits(s));
    while (!finished && cyc < 300) begin
      ab16 = 1'b0;
      or16 = 1'($urandom);
      if (idx < s.size()) begin
        iv16 = ($urandom_range(3) != 0);
        id16 = s[idx];
        il16 = (idx == s.size() - 1);
        m16  = (idx == 0) ? 1'b0 : 1'($urandom);
      end else begin
        iv16 = 1'b0;
        id16 = 8'($urandom);
        il16 = 1'b0;
      end
      @(negedge clk12);
      acc = iv16 & ir16;
      if (idx < s.size()) begin
        chk("chk_in_ready", 32'(ir16), 1);
        chk("chk_out_valid", 32'(ov16), 0);
        chk("chk_no_early_done", 32'(done16), 0);
        if (acc) begin
          if (idx == s.size() - 1) last_cyc = cyc;
          idx++;
        end
      end else if (cyc == last_cyc + 1) begin
        chk("chk_done", 32'(done16), 1);
        chk("chk_ok", 32'(ok16), 32'(exp_ok));
        chk("chk_crc_reg", 32'(crc16), 32'(brev(r, 16)));
        finished = 1;
      end
      @(posedge clk12);
      #1;
      cyc++;
    end
    iv16 = 1'b0;
    if (!finished) chk("chk_timeout", 0, 1);
  endtask

  // CHK packet on the CRC5 instance (one bit per beat).
  task automatic run_chk5(input bitq_t bits, input bit exp_ok, input bit timed);
    logic [15:0] r;
    int idx = 0, cyc = 0, last_cyc = -10;
    bit finished = 0, acc;
    r = ref_crc(16'h0014, 5, bits);
    while (!finished && cyc < 200) begin
      ab5 = 1'b0;
      or5 = 1'($urandom);
      if (idx < bits.size()) begin
        iv5 = timed ? 1'b1 : ($urandom_range(3) != 0);
        id5 = bits[idx];
        il5 = (idx == bits.size() - 1);
        m5  = (idx == 0) ? 1'b0 : 1'($urandom);
      end else begin
        iv5 = 1'b0;
        id5 = 1'($urandom);
        il5 = 1'b0;
      end
      @(negedge clk12);
      acc = iv5 & ir5;
      if (idx < bits.size()) begin
        chk("crc5_in_ready", 32'(ir5), 1);
        chk("crc5_out_valid", 32'(ov5), 0);
        chk("crc5_no_early_done", 32'(done5), 0);
        if (acc) begin
          if (idx == bits.size() - 1) last_cyc = cyc;
          idx++;
        end
      end else if (cyc == last_cyc + 1) begin
        chk("crc5_done", 32'(done5), 1);
        chk("crc5_ok", 32'(ok5), 32'(exp_ok));
        chk("crc5_reg", 32'(crc5), 32'(brev(r, 5)));
        if (exp_ok) chk("crc5_residual", 32'(crc5), 32'h0C);
        if (timed) chk("crc5_done_cycle", 32'(cyc), 16);
        finished = 1;
      end
      @(posedge clk12);
      #1;
      cyc++;
    end
    iv5 = 1'b0;
    if (!finished) chk("crc5_timeout", 0, 1);
  endtask

  initial begin
    vec16_t     tab16 [7];
    vec5_t      tab5 [4];
    logic [7:0] pl[$];
    logic [7:0] got[$];
    bitq_t      b;
    logic [15:0] r5, r1;

    tab16[0] = '{4,  1'b0, -1, 1'b1, 4'b1111};
    tab16[1] = '{4,  1'b0,  2, 1'b0, 4'b1001};
    tab16[2] = '{1,  1'b1, -1, 1'b1, 4'b1001};
    tab16[3] = '{7,  1'b1, -1, 1'b1, 4'b0110};
    tab16[4] = '{12, 1'b1,  5, 1'b0, 4'b1001};
    tab16[5] = '{3,  1'b1,  4, 1'b0, 4'b1011};
    tab16[6] = '{20, 1'b1, -1, 1'b1, 4'b1101};

    tab5[0] = '{11'h5A3, -1, 1'b1, 1'b1};
    tab5[1] = '{11'h001, -1, 1'b1, 1'b0};
    tab5[2] = '{11'h7C2,  3, 1'b0, 1'b0};
    tab5[3] = '{11'($urandom), 13, 1'b0, 1'b0};

    rst = 1'b1;
    m16 = 1'b1; ab16 = 1'b0; iv16 = 1'b0; id16 = '0; il16 = 1'b0; or16 = 1'b0;
    m5 = 1'b1; ab5 = 1'b0; iv5 = 1'b0; id5 = '0; il5 = 1'b0; or5 = 1'b0;
    repeat (2) @(posedge clk12);
    @(negedge clk12);
    chk("rst_crc16", 32'(crc16), 32'hFFFF);
    chk("rst_out_valid", 32'(ov16), 0);
    chk("rst_in_ready", 32'(ir16), 0);
    chk("rst_out_last", 32'(ol16), 0);
    chk("rst_done", 32'(done16), 0);
    chk("rst_ok", 32'(ok16), 0);
    chk("rst_crc5", 32'(crc5), 32'h1F);
    @(posedge clk12);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      pl.delete();
      for (int j = 0; j < tab16[i].len; j++) pl.push_back(tab16[i].rnd ? 8'($urandom) : 8'(j));
      run_gen16(pl, tab16[i].rnd, tab16[i].pat, got);
      run_chk16(got, tab16[i].flip, tab16[i].exp_ok);
      $display("crc16 packet %0d: len=%0d flip=%0d expect_ok=%0d", i, tab16[i].len, tab16[i].flip, tab16[i].exp_ok);
    end

    for (int i = 0; i < 4; i++) begin
      b.delete();
      for (int k = 0; k < 11; k++) b.push_back(tab5[i].tok[k]);
      r5 = ref_crc(16'h0014, 5, b);
      for (int k = 0; k < 5; k++) b.push_back(~r5[k]);
      if (tab5[i].flip >= 0) b[tab5[i].flip] = ~b[tab5[i].flip];
      run_chk5(b, tab5[i].exp_ok, tab5[i].timed);
      $display("crc5 token %0d: tok=%03h flip=%0d expect_ok=%0d", i, tab5[i].tok, tab5[i].flip, tab5[i].exp_ok);
    end

    // Abort on the second payload beat, then a fresh one-beat packet.
    m16 = 1'b1; or16 = 1'b1; iv16 = 1'b1; il16 = 1'b0; id16 = 8'hAA; ab16 = 1'b0;
    @(posedge clk12);
    #1;
    id16 = 8'hBB; ab16 = 1'b1;
    pl.delete();
    pl.push_back(8'hAA);
    r1 = ref_crc(16'hA001, 16, to_bits(pl));
    @(negedge clk12);
    chk("abort_pre_crc", 32'(crc16), 32'(brev(r1, 16)));
    @(posedge clk12);
    #1;
    ab16 = 1'b0; iv16 = 1'b0; m16 = 1'b0; or16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk12);
      chk("abort_no_done", 32'(done16), 0);
      chk("abort_crc_seed", 32'(crc16), 32'hFFFF);
      chk("abort_idle", 32'(ir16), 1);
      @(posedge clk12);
      #1;
    end
    pl.delete();
    pl.push_back(8'h5C);
    run_gen16(pl, 1'b0, 4'b1111, got);
    run_chk16(got, -1, 1'b1);
    $display("abort sequence done, fresh packet len=1");

    // Reset pulse while stalled in the appended CRC.
    m16 = 1'b1; or16 = 1'b1; iv16 = 1'b1; il16 = 1'b0; id16 = 8'h12;
    @(posedge clk12);
    #1;
    id16 = 8'h34; il16 = 1'b1;
    @(posedge clk12);
    #1;
    iv16 = 1'b0; il16 = 1'b0; or16 = 1'b0;
    @(negedge clk12);
    chk("rst_pre_append_valid", 32'(ov16), 1);
    @(posedge clk12);
    #1;
    rst = 1'b1;
    @(posedge clk12);
    #1;
    rst = 1'b0; m16 = 1'b0;
    @(negedge clk12);
    chk("rst_mid_out_valid", 32'(ov16), 0);
    chk("rst_mid_crc", 32'(crc16), 32'hFFFF);
    chk("rst_mid_done", 32'(done16), 0);
    chk("rst_mid_out_last", 32'(ol16), 0);
    chk("rst_mid_idle", 32'(ir16), 1);
    @(posedge clk12);
    #1;
    pl.delete();
    for (int j = 0; j < 3; j++) pl.push_back(8'($urandom));
    run_gen16(pl, 1'b1, 4'b1001, got);
    run_chk16(got, -1, 1'b1);
    $display("reset sequence done, fresh packet len=3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
